alu_mul: RTL and testbench

- Parametrised next-generation MiniRISC ALU, generalised to WIDTH bits.
- Keeps the single-cycle MOVE/ARITH/LOGIC/SHIFT datapath and the writable Z/C/N/V flags.
- Adds two new functions:
  - multi-bit shift/rotate by a count taken from operand2;
  - a multi-cycle unsigned shift-add multiplier with a start/busy/done handshake.
- Sits in the CPU execute stage. The controller stalls on busy and reads the 2*WIDTH-bit product on done.

---
 rtl/alu_mul.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_mul.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul
// Brief    : WIDTH-bit MiniRISC ALU with multi-bit shift/rotate and a
//            multi-cycle unsigned shift-add multiplier (start/busy/done).
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op_type,
  input  logic [1:0]       arith_sel,
  input  logic [1:0]       logic_sel,
  input  logic [3:0]       shift_sel,
  input  logic             shift_multi,
  input  logic             mul_start,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic             busy,
  output logic             done,
  input  logic [3:0]       flag_din,
  input  logic             flag_wr,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ALU_MOVE  = 2'd0;
  localparam logic [1:0] ALU_ARITH = 2'd1;
  localparam logic [1:0] ALU_LOGIC = 2'd2;
  localparam logic [1:0] ALU_SHIFT = 2'd3;

  localparam logic [1:0] LOGIC_AND = 2'd0;
  localparam logic [1:0] LOGIC_OR  = 2'd1;
  localparam logic [1:0] LOGIC_XOR = 2'd2;

  localparam logic [1:0] SH_SHL = 2'd0;
  localparam logic [1:0] SH_SHR = 2'd1;
  localparam logic [1:0] SH_ROL = 2'd2;

  localparam int Z_FLAG = 0;
  localparam int C_FLAG = 1;
  localparam int N_FLAG = 2;
  localparam int V_FLAG = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   prod_lo_q, prod_lo_d;
  logic [WIDTH-1:0]   prod_hi_q, prod_hi_d;
  logic [3:0]         flags_q, flags_d;

  logic               sub, cin, cout, ovf;
  logic [WIDTH-1:0]   op2_x;
  logic [WIDTH:0]     sum;

  logic [CW-1:0]      sh_n, idx_l, idx_r;
  logic [WIDTH-1:0]   sh_res, logic_res;
  logic               sh_fill, sh_c, thru_c;

  logic [WIDTH:0]     part;
  logic [2*WIDTH-1:0] step;
  logic               mul_fin;

  // Subtract is a + ~b + cin; carry flag is the inverted carry-out (borrow)
  always_comb begin
    sub   = arith_sel[1];
    op2_x = operand2 ^ {WIDTH{sub}};
    cin   = arith_sel[0] ? (flags_q[C_FLAG] ^ sub) : sub;
    sum   = {1'b0, operand1} + {1'b0, op2_x} + {{WIDTH{1'b0}}, cin};
    cout  = sum[WIDTH] ^ sub;
    ovf   = (operand1[WIDTH-1] == op2_x[WIDTH-1]) &&
            (sum[WIDTH-1] != operand1[WIDTH-1]);
  end

  always_comb begin
    logic_res = operand1 & operand2;
    case (logic_sel)
      LOGIC_AND: logic_res = operand1 & operand2;
      LOGIC_OR:  logic_res = operand1 | operand2;
      LOGIC_XOR: logic_res = operand1 ^ operand2;
      default:   logic_res = {operand1[WIDTH/2-1:0], operand1[WIDTH-1:WIDTH/2]};
    endcase
  end

  // Single-bit mode is the n=1 case plus rotate-through-carry on bit [2]
  always_comb begin
    sh_n    = shift_multi ? operand2[CW-1:0] : CW'(1);
    idx_l   = CW'(0) - sh_n;
    idx_r   = sh_n - CW'(1);
    thru_c  = !shift_multi && shift_sel[2];
    sh_fill = shift_sel[3] ? operand1[WIDTH-1] : shift_sel[2];
    sh_res  = operand1;
    sh_c    = flags_q[C_FLAG];
    case (shift_sel[1:0])
      SH_SHL: begin
        sh_res = (operand1 << sh_n) | (shift_sel[2] ? ~({WIDTH{1'b1}} << sh_n) : '0);
        sh_c   = operand1[idx_l];
      end
      SH_SHR: begin
        sh_res = (operand1 >> sh_n) | (sh_fill ? ~({WIDTH{1'b1}} >> sh_n) : '0);
        sh_c   = operand1[idx_r];
      end
      SH_ROL: begin
        sh_res = (operand1 << sh_n) | (operand1 >> idx_l);
        if (thru_c) sh_res[0] = flags_q[C_FLAG];
        sh_c   = operand1[idx_l];
      end
      default: begin
        sh_res = (operand1 >> sh_n) | (operand1 << idx_l);
        if (thru_c) sh_res[WIDTH-1] = flags_q[C_FLAG];
        sh_c   = operand1[idx_r];
      end
    endcase
  end

  always_comb begin
    result = operand2;
    case (op_type)
      ALU_MOVE:  result = operand2;
      ALU_ARITH: result = sum[WIDTH-1:0];
      ALU_LOGIC: result = logic_res;
      default:   result = sh_res;
    endcase
  end

  // acc holds {partial product, remaining multiplier}; shifts right each step
  always_comb begin
    part      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    step      = {part, acc_q[WIDTH-1:1]};
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    prod_lo_d = prod_lo_q;
    prod_hi_d = prod_hi_q;
    mul_fin   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (mul_start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          mcand_d = operand1;
          acc_d   = {{WIDTH{1'b0}}, operand2};
        end
      end
      S_RUN: begin
        acc_d = step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d                = S_DONE;
          mul_fin                = 1'b1;
          {prod_hi_d, prod_lo_d} = step;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (mul_fin) begin
      flags_d[Z_FLAG] = (step == '0);
      flags_d[N_FLAG] = step[2*WIDTH-1];
      flags_d[C_FLAG] = (step[2*WIDTH-1:WIDTH] != '0);
    end else if (state_q != S_RUN) begin
      case (op_type)
        ALU_ARITH: begin
          flags_d[Z_FLAG] = (arith_sel == 2'b11) ? (flags_q[Z_FLAG] && (sum[WIDTH-1:0] == '0))
                                                  : (sum[WIDTH-1:0] == '0);
          flags_d[C_FLAG] = cout;
          flags_d[N_FLAG] = sum[WIDTH-1];
          flags_d[V_FLAG] = ovf;
        end
        ALU_LOGIC: begin
          flags_d[Z_FLAG] = (logic_res == '0);
          flags_d[N_FLAG] = logic_res[WIDTH-1];
        end
        ALU_SHIFT: begin
          flags_d[Z_FLAG] = (sh_res == '0);
          flags_d[N_FLAG] = sh_res[WIDTH-1];
          if (sh_n != '0) flags_d[C_FLAG] = sh_c;
        end
        default: flags_d = flags_q;
      endcase
    end
    if (flag_wr) flags_d = flag_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      prod_lo_q <= prod_lo_d;
      prod_hi_q <= prod_hi_d;
      flags_q   <= flags_d;
    end
  end

  assign prod_lo = prod_lo_q;
  assign prod_hi = prod_hi_q;
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign flag_z  = flags_q[Z_FLAG];
  assign flag_c  = flags_q[C_FLAG];
  assign flag_n  = flags_q[N_FLAG];
  assign flag_v  = flags_q[V_FLAG];

endmodule
`default_nettype wire

// File: tb/tb_alu_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mul
// Brief    : Randomised scoreboard bench for alu_mul against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mul;

  localparam int W = 8;
  localparam logic [1:0] OP_MOVE  = 2'd0;
  localparam logic [1:0] OP_ARITH = 2'd1;
  localparam logic [1:0] OP_LOGIC = 2'd2;
  localparam logic [1:0] OP_SHIFT = 2'd3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     op_type = '0, arith_sel = '0, logic_sel = '0;
  logic [3:0]     shift_sel = '0;
  logic           shift_multi = 1'b0, mul_start = 1'b0;
  logic [W-1:0]   operand1 = '0, operand2 = '0;
  logic [W-1:0]   result, prod_lo, prod_hi;
  logic           busy, done;
  logic [3:0]     flag_din = '0;
  logic           flag_wr = 1'b0;
  logic           flag_z, flag_c, flag_n, flag_v;

  alu_mul #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .op_type(op_type), .arith_sel(arith_sel),
    .logic_sel(logic_sel), .shift_sel(shift_sel), .shift_multi(shift_multi),
    .mul_start(mul_start), .operand1(operand1), .operand2(operand2),
    .result(result), .prod_lo(prod_lo), .prod_hi(prod_hi), .busy(busy),
    .done(done), .flag_din(flag_din), .flag_wr(flag_wr), .flag_z(flag_z),
    .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] prod;
    logic [3:0]     flags;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  exp_t       expq[$];
  logic [3:0] mf = '0;   // model flags, {V,N,C,Z}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sgn(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - (1 << W) : int'(v);
  endfunction

  // Reference: plain integer arithmetic on the instruction's meaning
  function automatic void ref_op(input logic [1:0] ot, input logic [1:0] as,
                                 input logic [1:0] ls, input logic [3:0] ss,
                                 input logic sm, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [3:0] f,
                                 output logic [W-1:0] r, output logic [3:0] nf);
    int ia, ib, s, sr, n, cin, full, fillv;
    logic cf;
    ia = int'(a); ib = int'(b); full = (1 << W) - 1;
    cf = f[1]; nf = f; r = '0;
    case (ot)
      OP_MOVE: r = b;
      OP_ARITH: begin
        cin   = as[0] ? int'(cf) : 0;
        s     = as[1] ? ia - ib - cin : ia + ib + cin;
        sr    = as[1] ? sgn(a) - sgn(b) - cin : sgn(a) + sgn(b) + cin;
        r     = s[W-1:0];
        nf[1] = as[1] ? (s < 0) : (s > full);
        nf[3] = (sr > full / 2) || (sr < -(full / 2) - 1);
        nf[0] = (as == 2'b11) ? (f[0] && (r == 0)) : (r == 0);
        nf[2] = r[W-1];
      end
      OP_LOGIC: begin
        case (ls)
          2'd0:    r = a & b;
          2'd1:    r = a | b;
          2'd2:    r = a ^ b;
          default: r = W'((ia * (1 << (W / 2))) + (ia / (1 << (W / 2))));
        endcase
        nf[0] = (r == 0);
        nf[2] = r[W-1];
      end
      default: begin
        n = sm ? (ib % W) : 1;
        case (ss[1:0])
          2'd0: begin
            r = W'((ia << n) | (ss[2] ? (1 << n) - 1 : 0));
            if (n > 0) nf[1] = ((ia >> (W - n)) & 1) != 0;
          end
          2'd1: begin
            fillv = ss[3] ? int'(a[W-1]) : int'(ss[2]);
            r = W'((ia >> n) | ((fillv != 0) ? full - (full >> n) : 0));
            if (n > 0) nf[1] = ((ia >> (n - 1)) & 1) != 0;
          end
          2'd2: begin
            if (!sm && ss[2]) begin
              r = W'((ia << 1) | int'(cf));
              nf[1] = a[W-1];
            end else begin
              r = W'((ia << n) | (ia >> (W - n)));
              if (n > 0) nf[1] = ((ia >> (W - n)) & 1) != 0;
            end
          end
          default: begin
            if (!sm && ss[2]) begin
              r = W'((ia >> 1) | (int'(cf) << (W - 1)));
              nf[1] = a[0];
            end else begin
              r = W'((ia >> n) | (ia << (W - n)));
              if (n > 0) nf[1] = ((ia >> (n - 1)) & 1) != 0;
            end
          end
        endcase
        nf[0] = (r == 0);
        nf[2] = r[W-1];
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest pending product
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending product");
      end else begin
        e = expq.pop_front();
        chk("product", 32'({prod_hi, prod_lo}), 32'(e.prod));
        chk("mul_flags", 32'({flag_v, flag_n, flag_c, flag_z}), 32'(e.flags));
      end
    end
  end

  task automatic run_op(input logic [1:0] ot, input logic [1:0] as, input logic [1:0] ls,
                        input logic [3:0] ss, input logic sm, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic [W-1:0] got);
    logic [W-1:0] er;
    logic [3:0]   nf;
    @(negedge clk);
    op_type = ot; arith_sel = as; logic_sel = ls; shift_sel = ss;
    shift_multi = sm; operand1 = a; operand2 = b;
    #1;
    ref_op(ot, as, ls, ss, sm, a, b, mf, er, nf);
    got = result;
    chk("result", 32'(result), 32'(er));
    @(posedge clk);
    #1;
    mf = nf;
    chk("flags", 32'({flag_v, flag_n, flag_c, flag_z}), 32'(mf));
    op_type = OP_MOVE;
  endtask

  task automatic set_flags(input logic [3:0] v);
    @(negedge clk);
    flag_wr = 1'b1; flag_din = v;
    @(posedge clk);
    #1;
    flag_wr = 1'b0;
    mf = v;
    chk("flag_restore", 32'({flag_v, flag_n, flag_c, flag_z}), 32'(mf));
  endtask

  // Returns at the negedge of the done cycle (cycle W+1 after the start edge)
  task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit chained,
                     input bit pulse, input bit fw, input logic [3:0] fd);
    exp_t           e;
    bit             lat_ok;
    logic [2*W-1:0] p;
    if (!chained) @(negedge clk);
    p = (2*W)'(a) * (2*W)'(b);
    e.prod  = p;
    e.flags = fw ? fd : {mf[3], p[2*W-1], (p[2*W-1:W] != '0), (p == '0)};
    expq.push_back(e);
    op_type = OP_MOVE; operand1 = a; operand2 = b; mul_start = 1'b1;
    lat_ok = 1'b1;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      lat_ok = lat_ok && busy && !done;
      mul_start = pulse && (k == 4);
      if (pulse && k == 4) begin
        operand1 = W'($urandom);
        operand2 = W'($urandom);
      end
      if (k == W) begin
        flag_wr = fw; flag_din = fd;
      end
    end
    @(negedge clk);
    flag_wr = 1'b0;
    lat_ok = lat_ok && done && !busy;
    chk("mul_latency", 32'(lat_ok), 32'd1);
    mf = e.flags;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] got;
    repeat (2) @(negedge clk);
    chk("rst_prod", 32'({prod_hi, prod_lo}), 32'd0);
    chk("rst_busy_done", 32'({busy, done}), 32'd0);
    chk("rst_flags", 32'({flag_v, flag_n, flag_c, flag_z}), 32'd0);
    rst = 1'b0;

    run_op(OP_ARITH, 2'b00, 2'd0, 4'd0, 1'b0, 8'h7F, 8'h01, got);
    chk("add_res", 32'(got), 32'h80);
    chk("add_flags", 32'({flag_v, flag_n, flag_c, flag_z}), 32'b1100);

    run_op(OP_ARITH, 2'b10, 2'd0, 4'd0, 1'b0, 8'h00, 8'h01, got);
    chk("sub_res", 32'(got), 32'hFF);
    chk("sub_c", 32'(flag_c), 32'd1);
    run_op(OP_ARITH, 2'b11, 2'd0, 4'd0, 1'b0, 8'h00, 8'h00, got);
    chk("sbc_res", 32'(got), 32'hFF);
    chk("sbc_z0", 32'(flag_z), 32'd0);
    set_flags(4'b0001);
    run_op(OP_ARITH, 2'b11, 2'd0, 4'd0, 1'b0, 8'h00, 8'h00, got);
    chk("sbc_chain_res", 32'(got), 32'h00);
    chk("sbc_z1", 32'(flag_z), 32'd1);

    set_flags(4'b1000);
    mul(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("mul_ff_prod", 32'({prod_hi, prod_lo}), 32'hFE01);
    chk("mul_ff_flags", 32'({flag_v, flag_n, flag_c, flag_z}), 32'b1110);
    @(negedge clk);
    chk("done_one_cycle", 32'({busy, done}), 32'd0);

    run_op(OP_SHIFT, 2'b00, 2'd0, 4'b0000, 1'b1, 8'h81, 8'd3, got);
    chk("shl3_res", 32'(got), 32'h08);
    chk("shl3_c", 32'(flag_c), 32'd0);
    run_op(OP_SHIFT, 2'b00, 2'd0, 4'b1001, 1'b1, 8'h81, 8'd1, got);
    chk("asr1_res", 32'(got), 32'hC0);
    chk("asr1_c", 32'(flag_c), 32'd1);
    run_op(OP_SHIFT, 2'b00, 2'd0, 4'b0011, 1'b1, 8'h81, 8'd4, got);
    chk("ror4_res", 32'(got), 32'h18);
    set_flags(4'b0010);
    run_op(OP_SHIFT, 2'b00, 2'd0, 4'b0000, 1'b1, 8'h81, 8'h08, got);
    chk("sh0_res", 32'(got), 32'h81);
    chk("sh0_flags", 32'({flag_v, flag_n, flag_c, flag_z}), 32'b0110);

    // Abort a multiply with reset in its fifth busy cycle
    set_flags(4'b1111);
    @(negedge clk);
    operand1 = 8'hFF; operand2 = 8'hAB; mul_start = 1'b1;
    @(negedge clk);
    mul_start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy_done", 32'({busy, done}), 32'd0);
    chk("abort_prod", 32'({prod_hi, prod_lo}), 32'd0);
    chk("abort_flags", 32'({flag_v, flag_n, flag_c, flag_z}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mf = '0;
    mul(8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("after_abort_prod", 32'({prod_hi, prod_lo}), 32'h000F);
    chk("after_abort_z", 32'(flag_z), 32'd0);

    set_flags(4'b1111);
    mul(8'h00, 8'h12, 1'b0, 1'b0, 1'b1, 4'b0000);
    chk("restore_wins_flags", 32'({flag_v, flag_n, flag_c, flag_z}), 32'd0);
    chk("restore_wins_prod", 32'({prod_hi, prod_lo}), 32'd0);

    for (int i = 0; i < 160; i++) begin
      run_op(2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), 1'($urandom),
             W'($urandom), W'($urandom), got);
    end

    for (int i = 0; i < 16; i++) begin
      mul(W'($urandom), (i % 4 == 1) ? 8'h00 : W'($urandom), (i > 0) && ($urandom_range(0, 1) == 1),
          (i % 5 == 2), ($urandom_range(0, 7) == 0), 4'($urandom));
    end

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), 1'($urandom),
             W'($urandom), W'($urandom), got);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
